ram_requester: RTL and testbench

//   Initiator end of the ram_if protocol. Accepts one CPU-side load/store request
//   (byte/half/word, signed/unsigned), drives ren/wen/addr/store toward the SRAM
//   and holds them until the SRAM reports RAM_DONE. It then aligns and extends the

---
 rtl/ram_requester_if.sv | 35 +++
 rtl/ram_requester.sv | 211 +++++++++++++++++++++
 tb/tb_ram_requester.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_requester_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : ram_pkg                                                        |
// | Interface : ram_if                                                         |
// | Purpose   : Shared SRAM handshake types and the initiator/responder bus    |
// |             between a requester (CPU side) and the SRAM.                   |
// | Signals   : ren         read enable (initiator -> SRAM)                    |
// |             wen[3:0]    per-byte write enable (initiator -> SRAM)          |
// |             addr[31:0]  word-aligned byte address (initiator -> SRAM)      |
// |             store[31:0] lane-replicated write data (initiator -> SRAM)     |
// |             load[31:0]  read data (SRAM -> initiator)                      |
// |             state       SRAM handshake state (SRAM -> initiator)           |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package ram_pkg;
  typedef enum logic [1:0] {
    RAM_FREE  = 2'b00,
    RAM_BUSY  = 2'b01,
    RAM_DONE  = 2'b10,
    RAM_ERROR = 2'b11
  } ram_state_t;
endpackage

interface ram_if;
  logic                ren;
  logic [3:0]          wen;
  logic [31:0]         addr;
  logic [31:0]         store;
  logic [31:0]         load;
  ram_pkg::ram_state_t state;

  modport cpu (output ren, wen, addr, store, input load, state);
  modport ram (input ren, wen, addr, store, output load, state);
endinterface
`default_nettype wire

// File: rtl/ram_requester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : ram_requester                                                  |
// | Purpose   : Initiator end of ram_if. Takes one CPU load/store (byte, half, |
// |             word; signed/unsigned loads), drives the SRAM until RAM_DONE,  |
// |             then returns aligned/extended load data, or reports a fault    |
// |             for misaligned/illegal accesses or an SRAM timeout.            |
// | Ports     : clk, nrst (synchronous, active low)                            |
// |             cpu_req/cpu_we/cpu_size/cpu_uns/cpu_addr/cpu_wdata  request    |
// |             cpu_ack/cpu_rdata/cpu_fault                         response   |
// |             ramif (ram_if.cpu)                                  SRAM side  |
// | Params    : TIMEOUT - max ACCESS cycles without RAM_DONE before a fault    |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module ram_requester #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_uns,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        cpu_fault,
  ram_if.cpu          ramif
);

  localparam int unsigned         c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t             r_state,  w_state;
  logic               r_ren,    w_ren;
  logic [3:0]         r_wen,    w_wen;
  logic [31:0]        r_addr,   w_addr;
  logic [31:0]        r_store,  w_store;
  logic               r_ack,    w_ack;
  logic [31:0]        r_rdata,  w_rdata;
  logic               r_fault,  w_fault;
  logic [c_CNT_W-1:0] r_cnt,    w_cnt;
  logic [1:0]         r_size,   w_size;
  logic               r_uns,    w_uns;
  logic [1:0]         r_off,    w_off;

  logic               w_misaligned;
  logic [3:0]         w_lane_mask;
  logic [31:0]        w_store_data;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_load_ext;
  logic               w_done;

  // Request decode: size 11 is illegal; half/word must be naturally aligned.
  always_comb begin
    w_misaligned = 1'b0;
    w_lane_mask  = 4'b1111;
    w_store_data = cpu_wdata;
    case (cpu_size)
      2'b00: begin
        w_lane_mask  = 4'b0001 << cpu_addr[1:0];
        w_store_data = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        w_misaligned = cpu_addr[0];
        w_lane_mask  = cpu_addr[1] ? 4'b1100 : 4'b0011;
        w_store_data = {2{cpu_wdata[15:0]}};
      end
      2'b10: begin
        w_misaligned = (cpu_addr[1:0] != 2'b00);
      end
      default: begin
        w_misaligned = 1'b1;
      end
    endcase
  end

  // Load alignment and extension from the SRAM word, using the latched
  // byte offset, size and signedness of the pending request.
  always_comb begin
    w_byte     = ramif.load[{r_off, 3'b000} +: 8];
    w_half     = r_off[1] ? ramif.load[31:16] : ramif.load[15:0];
    w_load_ext = ramif.load;
    case (r_size)
      2'b00:   w_load_ext = {{24{~r_uns & w_byte[7]}}, w_byte};
      2'b01:   w_load_ext = {{16{~r_uns & w_half[15]}}, w_half};
      default: w_load_ext = ramif.load;
    endcase
  end

  assign w_done = (ramif.state == ram_pkg::RAM_DONE);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state = r_state;
    w_ren   = r_ren;
    w_wen   = r_wen;
    w_addr  = r_addr;
    w_store = r_store;
    w_ack   = 1'b0;
    w_rdata = r_rdata;
    w_fault = r_fault;
    w_cnt   = r_cnt;
    w_size  = r_size;
    w_uns   = r_uns;
    w_off   = r_off;
    case (r_state)
      S_IDLE: begin
        w_rdata = '0;
        w_fault = 1'b0;
        if (cpu_req) begin
          w_size = cpu_size;
          w_uns  = cpu_uns;
          w_off  = cpu_addr[1:0];
          if (w_misaligned) begin
            // Rejected without touching the SRAM.
            w_state = S_RESP;
            w_ack   = 1'b1;
            w_fault = 1'b1;
          end else begin
            w_state = S_ACCESS;
            w_addr  = {cpu_addr[31:2], 2'b00};
            w_cnt   = '0;
            if (cpu_we) begin
              w_wen   = w_lane_mask;
              w_store = w_store_data;
            end else begin
              w_ren   = 1'b1;
            end
          end
        end
      end
      S_ACCESS: begin
        w_cnt = r_cnt + 1'b1;
        // RAM_DONE takes priority over a timeout landing in the same cycle.
        if (w_done || (r_cnt == c_CNT_LAST)) begin
          w_state = S_RESP;
          w_ack   = 1'b1;
          w_ren   = 1'b0;
          w_wen   = 4'b0000;
          w_addr  = '0;
          w_store = '0;
          if (w_done) begin
            w_fault = 1'b0;
            w_rdata = r_ren ? w_load_ext : 32'h0;
          end else begin
            w_fault = 1'b1;
            w_rdata = '0;
          end
        end
      end
      S_RESP: begin
        // Request line is ignored here, forcing one idle cycle between requests.
        w_state = S_IDLE;
        w_rdata = '0;
        w_fault = 1'b0;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_ren   <= 1'b0;
      r_wen   <= 4'b0000;
      r_addr  <= '0;
      r_store <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_fault <= 1'b0;
      r_cnt   <= '0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_off   <= 2'b00;
    end else begin
      r_state <= w_state;
      r_ren   <= w_ren;
      r_wen   <= w_wen;
      r_addr  <= w_addr;
      r_store <= w_store;
      r_ack   <= w_ack;
      r_rdata <= w_rdata;
      r_fault <= w_fault;
      r_cnt   <= w_cnt;
      r_size  <= w_size;
      r_uns   <= w_uns;
      r_off   <= w_off;
    end
  end

  assign ramif.ren   = r_ren;
  assign ramif.wen   = r_wen;
  assign ramif.addr  = r_addr;
  assign ramif.store = r_store;
  assign cpu_ack     = r_ack;
  assign cpu_rdata   = r_rdata;
  assign cpu_fault   = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_ram_requester.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_ram_requester                                               |
// | Purpose   : Self-checking bench for ram_requester with a simple SRAM       |
// |             responder of configurable latency and a response scoreboard.  |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_ram_requester;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic        cpu_uns = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        cpu_fault;

  always #5 clk = ~clk;

  ram_if ram_bus ();

  ram_requester #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_size  (cpu_size),
    .cpu_uns   (cpu_uns),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .cpu_fault (cpu_fault),
    .ramif     (ram_bus.cpu)
  );

  // SRAM responder: RAM_DONE after LAT wait cycles (ACCESS cycle LAT+2).
  logic [31:0] mem [0:255];
  int          lat = 0;
  bit          never_done = 1'b0;
  int          rsp_cnt = 0;
  logic        active, done;
  logic [31:0] merged;

  assign active = ram_bus.ren || (ram_bus.wen != 4'b0000);
  assign done   = active && !never_done && (rsp_cnt == lat + 1);
  assign ram_bus.state = done ? ram_pkg::RAM_DONE :
                         (active ? ram_pkg::RAM_BUSY : ram_pkg::RAM_FREE);
  assign ram_bus.load  = mem[ram_bus.addr[9:2]];

  always_comb begin
    merged = mem[ram_bus.addr[9:2]];
    for (int i = 0; i < 4; i++)
      if (ram_bus.wen[i]) merged[8*i +: 8] = ram_bus.store[8*i +: 8];
  end

  always @(posedge clk) begin
    if (!nrst || !active || done) rsp_cnt <= 0;
    else                          rsp_cnt <= rsp_cnt + 1;
    if (done && ram_bus.wen != 4'b0000) mem[ram_bus.addr[9:2]] <= merged;
  end

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q [$];

  // Bus invariants and response scoreboard, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (nrst) begin
        checks++;
        if (ram_bus.ren && ram_bus.wen != 4'b0000) begin
          errors++;
          $display("FAIL ren_wen_exclusive: ren=%b wen=%b, required not both set", ram_bus.ren, ram_bus.wen);
        end
        checks++;
        if (!active && (ram_bus.addr !== 32'h0 || ram_bus.store !== 32'h0)) begin
          errors++;
          $display("FAIL bus_idle_zero: addr=%h store=%h, required 0 outside access", ram_bus.addr, ram_bus.store);
        end
        if (cpu_ack) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack: fault=%b rdata=%h, required no ack", cpu_fault, cpu_rdata);
          end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            if ({cpu_fault, cpu_rdata} !== e) begin
              errors++;
              $display("FAIL response: fault=%b rdata=%h, required fault=%b rdata=%h", cpu_fault, cpu_rdata, e[32], e[31:0]);
            end
          end
        end
      end
    end
  end

  int          ack_cyc, act_cyc;
  logic [3:0]  seen_wen;
  logic [31:0] seen_store, seen_addr;

  // Drives one request from cycle 0, measures ack cycle and active bus cycles.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [32:0] exp);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_uns = uns;
    cpu_addr = addr; cpu_wdata = wdata;
    exp_q.push_back(exp);
    ack_cyc = -1; act_cyc = 0; seen_wen = '0; seen_store = '0; seen_addr = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (active) begin
        act_cyc++;
        seen_wen = ram_bus.wen; seen_store = ram_bus.store; seen_addr = ram_bus.addr;
      end
      if (cpu_ack) begin
        ack_cyc = c;
        break;
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; cpu_req = 1'b1; cpu_size = 2'b10; cpu_addr = 32'h100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cpu_ack, cpu_fault, cpu_rdata} !== 34'h0) begin
      errors++;
      $display("FAIL reset_cpu: ack=%b fault=%b rdata=%h, required all 0", cpu_ack, cpu_fault, cpu_rdata);
    end
    checks++;
    if ({ram_bus.ren, ram_bus.wen, ram_bus.addr, ram_bus.store} !== 69'h0) begin
      errors++;
      $display("FAIL reset_bus: ren=%b wen=%b addr=%h store=%h, required all 0", ram_bus.ren, ram_bus.wen, ram_bus.addr, ram_bus.store);
    end
    cpu_req = 1'b0; nrst = 1'b1;
  endtask

  task automatic test_word_load();
    lat = 0;
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, {1'b0, 32'hDEADBEEF});
    checks++;
    if (ack_cyc !== 3 || act_cyc !== 2) begin
      errors++;
      $display("FAIL word_load_latency: ack cycle %0d ren cycles %0d, required 3 and 2", ack_cyc, act_cyc);
    end
    checks++;
    if (seen_addr !== 32'h100 || seen_wen !== 4'b0000) begin
      errors++;
      $display("FAIL word_load_bus: addr=%h wen=%b, required 00000100 and 0000", seen_addr, seen_wen);
    end
  endtask

  task automatic test_load_extend();
    lat = 1;
    mem[64] = 32'h80FF0011;
    issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, {1'b0, 32'hFFFFFF80});
    checks++;
    if (ack_cyc !== 4 || act_cyc !== 3 || seen_addr !== 32'h100) begin
      errors++;
      $display("FAIL byte_load_lat1: ack %0d ren %0d addr=%h, required 4, 3, 00000100", ack_cyc, act_cyc, seen_addr);
    end
    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, {1'b0, 32'h00000080});
    issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, {1'b0, 32'hFFFF80FF});
    issue(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, {1'b0, 32'h000080FF});
    issue(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, {1'b0, 32'h00000011});
    issue(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, {1'b0, 32'hFFFFFFFF});
    issue(1'b0, 2'b00, 1'b1, 32'h102, 32'h0, {1'b0, 32'h000000FF});
    issue(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, {1'b0, 32'h00000000});
  endtask

  task automatic test_store();
    lat = 0;
    issue(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, {1'b0, 32'h0});
    checks++;
    if (seen_wen !== 4'b1100 || seen_store !== 32'hABCDABCD || seen_addr !== 32'h200 || ack_cyc !== 3) begin
      errors++;
      $display("FAIL half_store: wen=%b store=%h addr=%h ack %0d, required 1100 ABCDABCD 00000200 3", seen_wen, seen_store, seen_addr, ack_cyc);
    end
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, {1'b0, 32'hABCD0000});
    issue(1'b1, 2'b00, 1'b0, 32'h201, 32'hFFFFFF5A, {1'b0, 32'h0});
    checks++;
    if (seen_wen !== 4'b0010 || seen_store !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL byte_store: wen=%b store=%h, required 0010 5A5A5A5A", seen_wen, seen_store);
    end
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, {1'b0, 32'hABCD5A00});
    issue(1'b1, 2'b10, 1'b0, 32'h204, 32'h12345678, {1'b0, 32'h0});
    checks++;
    if (seen_wen !== 4'b1111 || seen_store !== 32'h12345678) begin
      errors++;
      $display("FAIL word_store: wen=%b store=%h, required 1111 12345678", seen_wen, seen_store);
    end
    issue(1'b0, 2'b01, 1'b1, 32'h206, 32'h0, {1'b0, 32'h00001234});
  endtask

  task automatic test_fault();
    issue(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, {1'b1, 32'h0});
    checks++;
    if (ack_cyc !== 1 || act_cyc !== 0) begin
      errors++;
      $display("FAIL misaligned_word: ack %0d bus cycles %0d, required 1 and 0", ack_cyc, act_cyc);
    end
    issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, {1'b1, 32'h0});
    checks++;
    if (ack_cyc !== 1 || act_cyc !== 0) begin
      errors++;
      $display("FAIL illegal_size: ack %0d bus cycles %0d, required 1 and 0", ack_cyc, act_cyc);
    end
    issue(1'b1, 2'b01, 1'b0, 32'h103, 32'hFFFF, {1'b1, 32'h0});
    checks++;
    if (ack_cyc !== 1 || act_cyc !== 0) begin
      errors++;
      $display("FAIL misaligned_half_store: ack %0d bus cycles %0d, required 1 and 0", ack_cyc, act_cyc);
    end
  endtask

  task automatic test_timeout();
    never_done = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, {1'b1, 32'h0});
    never_done = 1'b0;
    checks++;
    if (ack_cyc !== 9 || act_cyc !== 8) begin
      errors++;
      $display("FAIL timeout: ack %0d ren cycles %0d, required 9 and 8", ack_cyc, act_cyc);
    end
    // Done in the last allowed cycle wins; one cycle later is a timeout.
    lat = 6;
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, {1'b0, 32'h80FF0011});
    checks++;
    if (ack_cyc !== 9 || act_cyc !== 8) begin
      errors++;
      $display("FAIL done_at_limit: ack %0d ren cycles %0d, required 9 and 8", ack_cyc, act_cyc);
    end
    lat = 7;
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, {1'b1, 32'h0});
    checks++;
    if (ack_cyc !== 9 || act_cyc !== 8) begin
      errors++;
      $display("FAIL done_past_limit: ack %0d ren cycles %0d, required 9 and 8", ack_cyc, act_cyc);
    end
  endtask

  task automatic test_reset_mid_access();
    lat = 3;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_uns = 1'b0; cpu_addr = 32'h100;
    repeat (2) @(negedge clk);
    checks++;
    if (ram_bus.ren !== 1'b1) begin
      errors++;
      $display("FAIL mid_access_ren: ren=%b, required 1", ram_bus.ren);
    end
    @(negedge clk);
    nrst = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_bus.ren !== 1'b0 || ram_bus.wen !== 4'b0000 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL mid_access_reset: ren=%b wen=%b ack=%b, required 0 0000 0", ram_bus.ren, ram_bus.wen, cpu_ack);
    end
    nrst = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, {1'b0, 32'h80FF0011});
    checks++;
    if (ack_cyc !== 6 || act_cyc !== 5) begin
      errors++;
      $display("FAIL after_reset_load: ack %0d ren cycles %0d, required 6 and 5", ack_cyc, act_cyc);
    end
  endtask

  task automatic test_back_to_back();
    lat = 0;
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, {1'b0, 32'hABCD5A00});
    issue(1'b0, 2'b00, 1'b1, 32'h204, 32'h0, {1'b0, 32'h00000078});
    checks++;
    if (ack_cyc !== 3) begin
      errors++;
      $display("FAIL back_to_back_latency: ack %0d, required 3", ack_cyc);
    end
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_single_cycle: ack=%b, required 0", cpu_ack);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[64] = 32'hDEADBEEF;
    test_reset();
    test_word_load();
    test_load_extend();
    test_store();
    test_fault();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_responses: %0d outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
